// File: rtl/wb_pkg.sv
// wb_pkg: shared Wishbone widths and the arbiter state encoding
package wb_pkg;
  localparam int ADR_W = 14;
  localparam int DAT_W = 32;
  localparam int SEL_W = 4;
  typedef enum logic [1:0] {IDLE = 2'd0, GNT0 = 2'd1, GNT1 = 2'd2} arb_state_t;
endpackage

// File: rtl/wb_arbiter2.sv
// wb_arbiter2: two-master round-robin Wishbone arbiter; define WB_ARB_TIMEOUT_EN for the stalled-strobe abort
module wb_arbiter2
  import wb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_cyc,
  input  logic             m0_stb,
  input  logic             m0_we,
  input  logic [ADR_W-1:0] m0_adr,
  input  logic [SEL_W-1:0] m0_sel,
  input  logic [DAT_W-1:0] m0_dat_mosi,
  output logic             m0_ack,
  output logic             m0_err,
  output logic [DAT_W-1:0] m0_dat_miso,
  input  logic             m1_cyc,
  input  logic             m1_stb,
  input  logic             m1_we,
  input  logic [ADR_W-1:0] m1_adr,
  input  logic [SEL_W-1:0] m1_sel,
  input  logic [DAT_W-1:0] m1_dat_mosi,
  output logic             m1_ack,
  output logic             m1_err,
  output logic [DAT_W-1:0] m1_dat_miso,
  output logic             s_cyc,
  output logic             s_stb,
  output logic             s_we,
  output logic [ADR_W-1:0] s_adr,
  output logic [SEL_W-1:0] s_sel,
  output logic [DAT_W-1:0] s_dat_mosi,
  input  logic             s_ack,
  input  logic [DAT_W-1:0] s_dat_miso,
  output logic [1:0]       grant,
  output logic             timeout
);
  arb_state_t state, state_n;
  logic last_grant, last_grant_n;
  logic g0, g1, own_cyc, own_stb, abort;
  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("wb_arbiter2: TIMEOUT_CYCLES must be 2..255");
  end
  assign g0 = state == GNT0;
  assign g1 = state == GNT1;
  assign own_cyc = (g0 & m0_cyc) | (g1 & m1_cyc);
  assign own_stb = (g0 & m0_stb) | (g1 & m1_stb);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      last_grant <= 1'b1;
    end else begin
      state <= state_n;
      last_grant <= last_grant_n;
    end
  // m0 wins a tie unless it was the last owner
  always_comb begin
    state_n = state;
    last_grant_n = last_grant;
    if (state == IDLE) begin
      if (m0_cyc && (!m1_cyc || last_grant)) begin
        state_n = GNT0;
        last_grant_n = 1'b0;
      end else if (m1_cyc) begin
        state_n = GNT1;
        last_grant_n = 1'b1;
      end
    end else if (!own_cyc) state_n = IDLE;
  end
`ifdef WB_ARB_TIMEOUT_EN
  logic [7:0] cnt;
  assign abort = own_stb && cnt == 8'(TIMEOUT_CYCLES - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt <= '0;
    else if (!own_cyc || s_ack || abort) cnt <= '0;
    else if (own_stb) cnt <= cnt + 8'd1;
`else
  assign abort = 1'b0;
`endif
  assign s_cyc = own_cyc;
  assign s_stb = own_stb & ~abort;
  assign s_we = (g0 & m0_we) | (g1 & m1_we);
  assign s_adr = g0 ? m0_adr : g1 ? m1_adr : '0;
  assign s_sel = g0 ? m0_sel : g1 ? m1_sel : '0;
  assign s_dat_mosi = g0 ? m0_dat_mosi : g1 ? m1_dat_mosi : '0;
  assign m0_ack = s_ack & g0 & ~abort;
  assign m1_ack = s_ack & g1 & ~abort;
  assign m0_err = abort & g0;
  assign m1_err = abort & g1;
  assign m0_dat_miso = s_dat_miso;
  assign m1_dat_miso = s_dat_miso;
  assign grant = {g1, g0};
  assign timeout = abort;
endmodule

// File: tb/tb_wb_arbiter2.sv
// tb_wb_arbiter2: randomized scoreboard bench against a transaction-level arbiter model
module tb_wb_arbiter2;
  localparam int T = 4;
`ifdef WB_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  logic clk = 0, rst_n = 0;
  logic m0_cyc = 0, m0_stb = 0, m0_we = 0, m1_cyc = 0, m1_stb = 0, m1_we = 0;
  logic [13:0] m0_adr = 0, m1_adr = 0, s_adr;
  logic [3:0] m0_sel = 0, m1_sel = 0, s_sel;
  logic [31:0] m0_dat_mosi = 0, m1_dat_mosi = 0, s_dat_mosi, s_dat_miso = 0, m0_dat_miso, m1_dat_miso;
  logic m0_ack, m0_err, m1_ack, m1_err, s_cyc, s_stb, s_we, s_ack = 0, timeout;
  logic [1:0] grant;
  typedef struct packed {
    logic cyc, stb, we;
    logic [13:0] adr;
    logic [3:0] sel;
    logic [31:0] dat;
    logic ack0, err0, ack1, err1;
    logic [1:0] grant;
    logic timeout;
    logic [31:0] miso0, miso1;
  } obs_t;
  obs_t exp_q[$];
  int errors = 0, checks = 0, cyc_no = 0;
  int owner = -1, last = 1, stall = 0;
  wb_arbiter2 #(.TIMEOUT_CYCLES(T)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_cyc(m0_cyc), .m0_stb(m0_stb), .m0_we(m0_we), .m0_adr(m0_adr), .m0_sel(m0_sel),
    .m0_dat_mosi(m0_dat_mosi), .m0_ack(m0_ack), .m0_err(m0_err), .m0_dat_miso(m0_dat_miso),
    .m1_cyc(m1_cyc), .m1_stb(m1_stb), .m1_we(m1_we), .m1_adr(m1_adr), .m1_sel(m1_sel),
    .m1_dat_mosi(m1_dat_mosi), .m1_ack(m1_ack), .m1_err(m1_err), .m1_dat_miso(m1_dat_miso),
    .s_cyc(s_cyc), .s_stb(s_stb), .s_we(s_we), .s_adr(s_adr), .s_sel(s_sel),
    .s_dat_mosi(s_dat_mosi), .s_ack(s_ack), .s_dat_miso(s_dat_miso),
    .grant(grant), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic obs_t observe();
    obs_t a;
    a.cyc = s_cyc; a.stb = s_stb; a.we = s_we; a.adr = s_adr; a.sel = s_sel; a.dat = s_dat_mosi;
    a.ack0 = m0_ack; a.err0 = m0_err; a.ack1 = m1_ack; a.err1 = m1_err;
    a.grant = grant; a.timeout = timeout; a.miso0 = m0_dat_miso; a.miso1 = m1_dat_miso;
    return a;
  endfunction
  always @(negedge clk)
    if (exp_q.size() > 0) begin
      obs_t e, a;
      e = exp_q.pop_front();
      a = observe();
      checks++;
      cyc_no++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle%0d: got %h expected %h", cyc_no, a, e);
      end
    end
  task automatic check_reset(input string name);
    obs_t e, a;
    e = '0;
    e.miso0 = s_dat_miso;
    e.miso1 = s_dat_miso;
    a = observe();
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask
  task automatic step(input bit c0, s0, c1, s1, ack);
    obs_t e;
    bit ab, oc, os;
    @(posedge clk);
    #1;
    m0_cyc = c0; m0_stb = s0; m0_we = 1'($urandom); m0_adr = 14'($urandom); m0_sel = 4'($urandom);
    m0_dat_mosi = $urandom;
    m1_cyc = c1; m1_stb = s1; m1_we = 1'($urandom); m1_adr = 14'($urandom); m1_sel = 4'($urandom);
    m1_dat_mosi = $urandom;
    s_ack = ack; s_dat_miso = $urandom;
    oc = owner == 0 ? c0 : c1;
    os = owner == 0 ? s0 : s1;
    ab = TO_EN && owner >= 0 && os && stall == T - 1;
    e = '0;
    if (owner == 0) begin
      e.we = m0_we; e.adr = m0_adr; e.sel = m0_sel; e.dat = m0_dat_mosi;
      e.ack0 = ack && !ab; e.err0 = ab; e.grant = 2'b01;
    end else if (owner == 1) begin
      e.we = m1_we; e.adr = m1_adr; e.sel = m1_sel; e.dat = m1_dat_mosi;
      e.ack1 = ack && !ab; e.err1 = ab; e.grant = 2'b10;
    end
    if (owner >= 0) begin
      e.cyc = oc;
      e.stb = os && !ab;
    end
    e.timeout = ab;
    e.miso0 = s_dat_miso;
    e.miso1 = s_dat_miso;
    exp_q.push_back(e);
    if (owner < 0) begin
      if (c0 && c1) owner = 1 - last;
      else if (c0) owner = 0;
      else if (c1) owner = 1;
      if (owner >= 0) last = owner;
      stall = 0;
    end else if (!oc) begin
      owner = -1;
      stall = 0;
    end else if (ack || ab) stall = 0;
    else if (os) stall++;
  endtask
  initial begin
    bit c0, c1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset_hold");
    #1 rst_n = 1;
    repeat (3) step(1, 1, 1, 1, 0);
    step(0, 0, 1, 1, 1);
    repeat (2) step(0, 0, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (3) begin
      repeat (2) step(1, 1, 1, 1, 1);
      repeat (2) step(0, 0, 0, 0, 0);
    end
    repeat (11) step(1, 1, 0, 0, 0);
    step(1, 1, 0, 0, 1);
    repeat (6) step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(5) == 0) c0 = !c0;
      if ($urandom_range(5) == 0) c1 = !c1;
      step(c0, 1'($urandom), c1, 1'($urandom), $urandom_range(3) == 0);
    end
    repeat (2) step(0, 0, 0, 0, 0);
    repeat (4) step(0, 0, 1, 1, 0);
    @(negedge clk);
    #2 rst_n = 0;
    #1 check_reset("reset_async");
    m1_cyc = 0;
    m1_stb = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset("reset_mid");
    #1 rst_n = 1;
    owner = -1;
    last = 1;
    stall = 0;
    repeat (3) step(1, 1, 1, 1, 0);
    step(0, 0, 0, 0, 0);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
